johnson_seq_ctrl: RTL and testbench
===================================

# johnson_seq_ctrl

Controller that sequences a parameterised N-stage Johnson counter. It runs a requested number of steps in a selected direction, then reports completion, and supports abort and parallel load with illegal-pattern recovery. It produces the raw counter state and a one-hot decode of the 2N phases. It sits between a control master (start/stop/steps) and downstream logic that consumes Johnson phases as time slots.

## Interface
- N, 3, number of counter stages; 2N phases; N >= 2
- CW, 8, width of step-count input and internal remaining-steps counter
- clk  input  1  rising-edge clock, sole clock domain
- mrst  input  1  master reset, synchronous, active-high
- start  input  1  run request, sampled in IDLE only
- stop  input  1  abort request, sampled in RUN only
- dir  input  1  0 = forward, 1 = reverse; latched on accepted start
- steps  input  CW  number of steps to run; latched on accepted start
- load  input  1  parallel-load request, honoured in IDLE only
- load_val  input  N  value to load
- q  output  N  counter state, registered
- phase_oh  output  2N  one-hot phase decode of q, combinational from q
- busy  output  1  high while in RUN, registered
- done  output  1  one-cycle pulse, run completed normally
- aborted  output  1  one-cycle pulse, run terminated by stop
- err  output  1  one-cycle pulse, load_val was not a legal Johnson pattern

## Operation
- Reset (mrst=1 at rising edge):
  - q=0, busy=0, done=0, aborted=0, err=0.
  - State IDLE; remaining=0; latched dir=0.
  - Reset overrides every other input in that cycle, including mid-run.
- Forward step: q <= {q[N-2:0], ~q[N-1]}. For N=3: 000→001→011→111→110→100→000.
- Reverse step: q <= {~q[0], q[N-1:1]}. This is the exact inverse of the forward step.
- Phase index for N=3: 000=0, 001=1, 011=2, 111=3, 110=4, 100=5. General rule: index k<N has the low k bits set; index N+k has the low k bits clear and the rest set. phase_oh[index]=1; all other bits are 0.
- Legal pattern: at most one i in [0,N-2] with q[i]≠q[i+1].
- States:
  - IDLE
    - Priority: load > start.
    - load=1: if load_val is legal, q<=load_val and err stays 0. If illegal, q<=0 and err pulses. start in the same cycle is ignored.
    - start=1, steps≠0: go to RUN, busy<=1, remaining<=steps, latch dir. q does not move on this edge.
    - start=1, steps=0: stay IDLE; done pulses next cycle; q is unchanged.
    - stop is ignored.
  - RUN
    - Priority: stop > step.
    - stop=1: go to IDLE without stepping; busy<=0; aborted pulses; remaining<=0.
    - Otherwise:
      - q steps once in the latched direction and remaining decrements.
      - When remaining==1 on this edge (final step): go to IDLE, busy<=0, done pulses.
    - start and load are ignored; dir changes have no effect until the next accepted start.
- Wrap-around: no limit on steps relative to 2N. The counter wraps freely; steps=2N returns q to its starting value.
- The remaining counter never underflows; remaining=0 is reachable only in IDLE.

## Timing
- Start acceptance: start at edge E0 makes busy=1 after E0. Steps occur at E1..E(steps). busy falls and done=1 after E(steps). done deasserts after E(steps+1).
- Total run latency: steps+1 edges from start to the done pulse.
- Abort: stop at edge Es (in RUN) makes busy=0 and aborted=1 after Es, with no step at Es. aborted clears after Es+1.
- A new start is accepted on the edge after busy falls. Back-to-back runs have a one-cycle IDLE gap minimum.
- err, done and aborted are each exactly one cycle wide and mutually exclusive in any cycle.
- phase_oh follows q combinationally with zero cycles of latency.

## Test plan
- Reset/forward run: mrst 1 cycle; start, dir=0, steps=6, N=3 → q goes 001,011,111,110,100,000 on E1..E6; busy high for 6 cycles; done=1 only in the cycle after E6; phase_oh=000001 at end.
- Reverse with wrap: q=000, start, dir=1, steps=8 → q goes 100,110,111,011,001,000,100,110; done after E8; phase_oh=010000.
- Abort: start with steps=10; stop asserted on the 3rd RUN edge → q has advanced 2 steps (011); busy=0; aborted pulses once; done stays 0; remaining=0.
- Load handling:
  - load_val=011 in IDLE → q=011, err=0.
  - load_val=101 → q=000, err pulses.
  - load during RUN → ignored, q continues stepping.
  - load+start together in IDLE → load wins, busy stays 0.
- Edge cases:
  - start with steps=0 → done pulses next cycle; busy never rises; q unchanged.
  - start while busy → ignored, run length unchanged.
  - mrst mid-run (after 3 of 6 steps) → q=000, busy=0, no done/aborted pulse.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Johnson counter run controller: runs a requested number of steps in either direction,
// supports abort and parallel load with illegal-pattern recovery, and decodes the 2N phases.
module johnson_seq_ctrl #(
    parameter int unsigned N  = 3,
    parameter int unsigned CW = 8
) (
    input  logic            clk,
    input  logic            mrst,
    input  logic            start,
    input  logic            stop,
    input  logic            dir,
    input  logic [CW-1:0]   steps,
    input  logic            load,
    input  logic [N-1:0]    load_val,
    output logic [N-1:0]    q,
    output logic [2*N-1:0]  phase_oh,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic            err
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    q_q, q_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic            dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            err_q, err_d;
    logic [N-1:0]    phase_pat;

    // A legal Johnson pattern has at most one boundary between runs of equal bits.
    function automatic logic is_legal(input logic [N-1:0] v);
        int unsigned edges;
        edges = 0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (v[i] != v[i+1]) begin
                edges++;
            end
        end
        return (edges <= 32'd1);
    endfunction

    function automatic logic [N-1:0] step_fwd(input logic [N-1:0] v);
        return {v[N-2:0], ~v[N-1]};
    endfunction

    function automatic logic [N-1:0] step_rev(input logic [N-1:0] v);
        return {~v[0], v[N-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (mrst) begin
            state_q     <= StIdle;
            q_q         <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    if (is_legal(load_val)) begin
                        q_d = load_val;
                    end else begin
                        q_d   = '0;
                        err_d = 1'b1;
                    end
                end else if (start) begin
                    if (steps != '0) begin
                        state_d     = StRun;
                        busy_d      = 1'b1;
                        remaining_d = steps;
                        dir_d       = dir;
                    end else begin
                        // Zero-length run completes immediately without touching q.
                        done_d = 1'b1;
                    end
                end
            end

            StRun: begin
                if (stop) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    aborted_d   = 1'b1;
                    remaining_d = '0;
                end else begin
                    q_d         = dir_q ? step_rev(q_q) : step_fwd(q_q);
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Phase k has the low k bits set; phase N+k is its bitwise complement.
    always_comb begin
        phase_oh  = '0;
        phase_pat = '0;
        for (int k = 0; k < int'(N); k++) begin
            phase_pat = '0;
            for (int j = 0; j < k; j++) begin
                phase_pat[j] = 1'b1;
            end
            if (q_q == phase_pat) begin
                phase_oh[k] = 1'b1;
            end
            if (q_q == ~phase_pat) begin
                phase_oh[N+k] = 1'b1;
            end
        end
    end

    assign q       = q_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign err     = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: a phase-index reference model pushes expected outputs
// per clock edge; a monitor on the falling edge pops and compares them.
module tb_johnson_seq_ctrl;

    localparam int N  = 3;
    localparam int P  = 2 * N;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            mrst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            dir = 1'b0;
    logic [CW-1:0]   steps = '0;
    logic            load = 1'b0;
    logic [N-1:0]    load_val = '0;
    logic [N-1:0]    q;
    logic [P-1:0]    phase_oh;
    logic            busy, done, aborted, err;

    johnson_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .mrst     (mrst),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .steps    (steps),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .phase_oh (phase_oh),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] q;
        logic [P-1:0] ph;
        logic         busy;
        logic         done;
        logic         ab;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Counter value for each phase index, straight from the phase numbering rule.
    int pat[P];
    initial begin
        for (int k = 0; k < N; k++) begin
            pat[k]     = (1 << k) - 1;
            pat[N + k] = ((1 << N) - 1) & ~((1 << k) - 1);
        end
    end

    // Reference model: tracks the phase index and run bookkeeping as plain integers.
    int m_p = 0, m_rem = 0;
    bit m_run = 0, m_dir = 0;
    always @(posedge clk) begin
        exp_t e;
        bit   m_done, m_ab, m_err, found;
        m_done = 0; m_ab = 0; m_err = 0;
        if (mrst) begin
            m_p = 0; m_run = 0; m_rem = 0; m_dir = 0;
        end else if (!m_run) begin
            if (load) begin
                found = 0;
                for (int k = 0; k < P; k++) begin
                    if (pat[k] == int'(load_val)) begin
                        m_p = k; found = 1;
                    end
                end
                if (!found) begin
                    m_p = 0; m_err = 1;
                end
            end else if (start) begin
                if (steps != 0) begin
                    m_run = 1; m_rem = int'(steps); m_dir = dir;
                end else begin
                    m_done = 1;
                end
            end
        end else begin
            if (stop) begin
                m_run = 0; m_ab = 1; m_rem = 0;
            end else begin
                m_p   = m_dir ? (m_p + P - 1) % P : (m_p + 1) % P;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_run = 0; m_done = 1;
                end
            end
        end
        e.q    = N'(pat[m_p]);
        e.ph   = P'(1 << m_p);
        e.busy = m_run;
        e.done = m_done;
        e.ab   = m_ab;
        e.err  = m_err;
        sb.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every falling edge, the DUT's registered outputs reflect the last rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("phase_oh", 32'(phase_oh), 32'(e.ph));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("aborted", 32'(aborted), 32'(e.ab));
            chk("err", 32'(err), 32'(e.err));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic st, input logic sp, input logic d,
                         input int n, input logic ld, input int lv);
        mrst = r; start = st; stop = sp; dir = d; steps = CW'(n);
        load = ld; load_val = N'(lv);
        tick();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Forward run of 2N steps returns to phase 0.
        drive(0, 1, 0, 0, 6, 0, 0);
        idle(8);
        // Reverse with wrap; dir wiggles mid-run must be ignored.
        drive(0, 1, 0, 1, 8, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        idle(8);
        // Abort on the third RUN edge.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 10, 0, 0);
        idle(2);
        drive(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        // Loads: legal, illegal, during run, and together with start.
        drive(0, 0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 0, 1, 5);
        drive(0, 1, 0, 0, 4, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 7);
        idle(5);
        drive(0, 1, 0, 0, 4, 1, 6);
        idle(2);
        // Zero-step start, start while busy, stop while idle.
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 3, 0, 0);
        drive(0, 1, 0, 0, 9, 0, 0);
        idle(4);
        // Back-to-back start right after done.
        drive(0, 1, 0, 0, 2, 0, 0);
        idle(2);
        drive(0, 1, 0, 0, 1, 0, 0);
        idle(2);
        // Reset mid-run after three steps.
        drive(0, 1, 0, 0, 6, 0, 0);
        idle(3);
        drive(1, 1, 0, 0, 6, 1, 3);
        idle(3);

        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20)),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 7)));
        end
        idle(2);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
